// File: rtl/fir_pkg.sv
// Shared constants and types for the 9-tap symmetric FIR datapath:
// sample width, tap count, output width and the symmetric coefficients.
package fir_pkg;

    localparam int SAMPLE_W  = 4;
    localparam int FIR_TAPS  = 9;
    localparam int FIR_OUT_W = 10;

    // Symmetric coefficients: tap k and tap (8-k) share FIR_B<k>; FIR_B4 is the centre.
    localparam int FIR_B0 = 2;
    localparam int FIR_B1 = 3;
    localparam int FIR_B2 = 6;
    localparam int FIR_B3 = 10;
    localparam int FIR_B4 = 12;

    localparam logic [3:0] FILL_MAX = 4'(FIR_TAPS);

    typedef logic [3:0] fill_t;

    // Saturating increment of the fill counter; it stops at FILL_MAX and never wraps.
    function automatic fill_t fill_next(input fill_t level);
        fill_t r_unused;
        r_unused = '0;
        if (level >= FILL_MAX) begin
            return FILL_MAX;
        end
        return level + 4'd1 + r_unused;
    endfunction

endpackage

// File: rtl/fir_tap_reg.sv
// One delay-line stage: DW-bit register with async active-low clear,
// synchronous clear and load enable.
module fir_tap_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_load,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fir_sample_window.sv
// Sample window feeder for the 9-tap FIR core: a 9-deep delay line filled
// from a valid/ready stream, presented as a window with its own valid/ready.
module fir_sample_window
    import fir_pkg::*;
#(
    parameter int DW = SAMPLE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] samples_0,
    output logic [DW-1:0] samples_1,
    output logic [DW-1:0] samples_2,
    output logic [DW-1:0] samples_3,
    output logic [DW-1:0] samples_4,
    output logic [DW-1:0] samples_5,
    output logic [DW-1:0] samples_6,
    output logic [DW-1:0] samples_7,
    output logic [DW-1:0] samples_8,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [3:0]    fill_level
);

    localparam int TAPS = FIR_TAPS;

    logic [DW-1:0] w_taps [TAPS];
    logic          w_accept;
    logic          w_consume;
    logic [3:0]    r_fill_level;
    logic          r_win_valid;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and a held window stays bit-stable until consumed.
    assign din_ready = !flush && (!r_win_valid || win_ready);
    assign w_accept  = din_valid && din_ready;
    assign w_consume = r_win_valid && win_ready;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        if (k == 0) begin : g_head
            fir_tap_reg #(.DW(DW)) u_tap (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_clr  (flush),
                .i_load (w_accept),
                .i_d    (din),
                .o_q    (w_taps[k])
            );
        end else begin : g_body
            fir_tap_reg #(.DW(DW)) u_tap (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_clr  (flush),
                .i_load (w_accept),
                .i_d    (w_taps[k-1]),
                .o_q    (w_taps[k])
            );
        end
    end

    // A window completes on the accept that brings the fill to 9; an accept
    // coinciding with a consume replaces the window so throughput stays 1/cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_level <= '0;
            r_win_valid  <= 1'b0;
        end else if (flush) begin
            r_fill_level <= '0;
            r_win_valid  <= 1'b0;
        end else if (w_accept) begin
            r_fill_level <= fill_next(r_fill_level);
            r_win_valid  <= (r_fill_level >= 4'(TAPS - 1));
        end else if (w_consume) begin
            r_win_valid  <= 1'b0;
        end
    end

    assign samples_0  = w_taps[0];
    assign samples_1  = w_taps[1];
    assign samples_2  = w_taps[2];
    assign samples_3  = w_taps[3];
    assign samples_4  = w_taps[4];
    assign samples_5  = w_taps[5];
    assign samples_6  = w_taps[6];
    assign samples_7  = w_taps[7];
    assign samples_8  = w_taps[8];
    assign win_valid  = r_win_valid;
    assign fill_level = r_fill_level;

endmodule

// File: tb/tb_fir_sample_window.sv
// Directed vector bench for fir_sample_window: fill, streaming, backpressure,
// drain, flush and asynchronous reset.
module tb_fir_sample_window;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [3:0] s0, s1, s2, s3, s4, s5, s6, s7, s8;
    logic       win_valid;
    logic       win_ready;
    logic [3:0] fill_level;
    logic [3:0] w_s [9];

    int checks;
    int failures;
    logic [3:0] exp_q [$];

    typedef struct {
        logic       fl;
        logic       v;
        logic [3:0] d;
        logic       wr;
        logic       e_rdy;
        logic       e_wv;
        logic [3:0] e_fill;
        logic [3:0] e_s0;
        logic [3:0] e_s8;
    } vec_t;

    vec_t vecs [$];

    fir_sample_window dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .samples_0  (s0),
        .samples_1  (s1),
        .samples_2  (s2),
        .samples_3  (s3),
        .samples_4  (s4),
        .samples_5  (s5),
        .samples_6  (s6),
        .samples_7  (s7),
        .samples_8  (s8),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .fill_level (fill_level)
    );

    assign w_s[0] = s0;
    assign w_s[1] = s1;
    assign w_s[2] = s2;
    assign w_s[3] = s3;
    assign w_s[4] = s4;
    assign w_s[5] = s5;
    assign w_s[6] = s6;
    assign w_s[7] = s7;
    assign w_s[8] = s8;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fl, input logic v, input logic [3:0] d,
                                input logic wr, input logic e_rdy, input logic e_wv,
                                input logic [3:0] e_fill, input logic [3:0] e_s0,
                                input logic [3:0] e_s8);
        vec_t t;
        t.fl = fl; t.v = v; t.d = d; t.wr = wr;
        t.e_rdy = e_rdy; t.e_wv = e_wv; t.e_fill = e_fill; t.e_s0 = e_s0; t.e_s8 = e_s8;
        return t;
    endfunction

    task automatic drive(input logic fl, input logic v, input logic [3:0] d, input logic wr);
        @(negedge clk);
        flush     = fl;
        din_valid = v;
        din       = d;
        win_ready = wr;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_win_valid"}, 8'(win_valid), 8'd0);
        chk({tag, "_fill"}, 8'(fill_level), 8'd0);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("%s_s%0d", tag, k), 8'(w_s[k]), 8'd0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        din = '0;
        din_valid = 1'b0;
        win_ready = 1'b0;

        // 1: fill 1..9 after reset
        for (int i = 1; i <= 9; i++) begin
            vecs.push_back(mk(0, 1, 4'(i), 1, 1, (i == 9), 4'(i), 4'(i), (i == 9) ? 4'd1 : 4'd0));
        end
        // 2: streaming
        vecs.push_back(mk(0, 1, 4'd10, 1, 1, 1, 4'd9, 4'd10, 4'd2));
        vecs.push_back(mk(0, 1, 4'd11, 1, 1, 1, 4'd9, 4'd11, 4'd3));
        // 3: backpressure, then release
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(0, 1, 4'd5, 0, 0, 1, 4'd9, 4'd11, 4'd3));
        end
        vecs.push_back(mk(0, 1, 4'd5, 1, 1, 1, 4'd9, 4'd5, 4'd4));
        // 4: drain, idle, re-raise on next accept
        vecs.push_back(mk(0, 0, 4'd0, 1, 1, 0, 4'd9, 4'd5, 4'd4));
        vecs.push_back(mk(0, 0, 4'd0, 0, 1, 0, 4'd9, 4'd5, 4'd4));
        vecs.push_back(mk(0, 1, 4'd6, 0, 1, 1, 4'd9, 4'd6, 4'd5));
        // 5: flush with a pending window being consumed and din valid
        vecs.push_back(mk(1, 1, 4'd7, 1, 0, 0, 4'd0, 4'd0, 4'd0));
        for (int i = 0; i < 9; i++) begin
            vecs.push_back(mk(0, 1, 4'(15 - i), 1, 1, (i == 8), 4'(i + 1), 4'(15 - i),
                              (i == 8) ? 4'd15 : 4'd0));
        end

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_din_ready", 8'(din_ready), 8'd1);
        check_all_zero("post_reset");

        for (int n = 0; n < vecs.size(); n++) begin
            drive(vecs[n].fl, vecs[n].v, vecs[n].d, vecs[n].wr);
            #1;
            chk($sformatf("v%0d_din_ready", n), 8'(din_ready), 8'(vecs[n].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_win_valid", n), 8'(win_valid), 8'(vecs[n].e_wv));
            chk($sformatf("v%0d_fill", n), 8'(fill_level), 8'(vecs[n].e_fill));
            chk($sformatf("v%0d_s0", n), 8'(s0), 8'(vecs[n].e_s0));
            chk($sformatf("v%0d_s8", n), 8'(s8), 8'(vecs[n].e_s8));
        end

        // Full ordering of the last window (fed 15 down to 7): samples_k = 7+k
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(4'(7 + k));
        end
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("order_s%0d", k), 8'(w_s[k]), 8'(exp_q.pop_front()));
        end

        // Window holds bit-stable under backpressure while din keeps changing
        drive(0, 1, 4'd2, 0);
        @(posedge clk);
        #1;
        chk("hold_s0", 8'(s0), 8'd7);
        chk("hold_s4", 8'(s4), 8'd11);
        chk("hold_win_valid", 8'(win_valid), 8'd1);

        // 6: async reset mid-stream with fill_level=5
        drive(1, 0, 4'd0, 1);
        @(posedge clk);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 4'(i + 2), 1);
        end
        drive(0, 0, 4'd0, 1);
        chk("pre_async_fill", 8'(fill_level), 8'd5);
        chk("pre_async_s0", 8'(s0), 8'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("async_rel_ready", 8'(din_ready), 8'd1);
        drive(0, 1, 4'd12, 1);
        @(posedge clk);
        #1;
        chk("after_async_fill", 8'(fill_level), 8'd1);
        chk("after_async_s0", 8'(s0), 8'd12);
        chk("after_async_s1", 8'(s1), 8'd0);
        chk("after_async_wv", 8'(win_valid), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
